// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - fetch/decode sequencer owning the PC, IR and control flow
// Control-only commands resolve in ISSUE; MOV/ACC/conditional JMP wait for the datapath handshake.
module instruction_sequencer #(
    parameter logic [7:0] RESET_ADDR = 8'd0
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        run_i,
    output logic [7:0]  instr_address_o,
    input  logic [31:0] instruction_i,
    input  logic [7:0]  flags_i,
    input  logic        cond_true_i,
    output logic        dec_valid_o,
    input  logic        exec_ready_i,
    output logic [2:0]  dec_cmd_o,
    output logic [2:0]  dec_op_o,
    output logic        arg1_type_o,
    output logic [7:0]  arg1_o,
    output logic        arg2_type_o,
    output logic [7:0]  arg2_o,
    output logic [7:0]  dec_addr_o,
    output logic        flag_ack_o,
    output logic [2:0]  flag_ack_bit_o
);

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_MOV = 3'd1;
    localparam logic [2:0] CMD_ACC = 3'd2;
    localparam logic [2:0] CMD_JMP = 3'd3;
    localparam logic [2:0] CMD_ATC = 3'd4;
    localparam logic [2:0] OP_UNC  = 3'd0;

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    logic [7:0]  pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [0:0]  state_q, state_d;
    logic [7:0]  pc_inc;

    assign instr_address_o = pc_q;
    assign dec_cmd_o       = ir_q[31:29];
    assign dec_op_o        = ir_q[28:26];
    assign arg1_type_o     = ir_q[25];
    assign arg1_o          = ir_q[24:17];
    assign arg2_type_o     = ir_q[16];
    assign arg2_o          = ir_q[15:8];
    assign dec_addr_o      = ir_q[7:0];
    assign pc_inc          = pc_q + 8'd1;

    always_comb begin
        pc_d           = pc_q;
        ir_d           = ir_q;
        state_d        = state_q;
        dec_valid_o    = 1'b0;
        flag_ack_o     = 1'b0;
        flag_ack_bit_o = 3'd0;
        if (state_q == ST_FETCH) begin
            if (run_i) begin
                ir_d    = instruction_i;
                state_d = ST_ISSUE;
            end
        end else begin
            case (dec_cmd_o)
                CMD_MOV, CMD_ACC: begin
                    dec_valid_o = 1'b1;
                    if (exec_ready_i) begin
                        pc_d    = pc_inc;
                        state_d = ST_FETCH;
                    end
                end
                CMD_JMP: begin
                    if (dec_op_o == OP_UNC) begin
                        pc_d    = dec_addr_o;
                        state_d = ST_FETCH;
                    end else begin
                        // cond_true only matters on the accepting cycle
                        dec_valid_o = 1'b1;
                        if (exec_ready_i) begin
                            pc_d    = cond_true_i ? dec_addr_o : pc_inc;
                            state_d = ST_FETCH;
                        end
                    end
                end
                CMD_ATC: begin
                    if (flags_i[dec_op_o]) begin
                        pc_d           = dec_addr_o;
                        flag_ack_o     = 1'b1;
                        flag_ack_bit_o = dec_op_o;
                    end else begin
                        pc_d = pc_inc;
                    end
                    state_d = ST_FETCH;
                end
                // CMD_NOP and undefined codes fall through to sequential fetch
                default: begin
                    pc_d    = pc_inc;
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            pc_q    <= RESET_ADDR;
            ir_q    <= 32'd0;
            state_q <= ST_FETCH;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb/tb_instruction_sequencer.sv - directed self-checking bench for instruction_sequencer
// Inputs change and outputs are checked on the falling edge; one task per scenario.
module tb_instruction_sequencer;

    localparam logic [2:0] NOP = 3'd0;
    localparam logic [2:0] MOV = 3'd1;
    localparam logic [2:0] ACC = 3'd2;
    localparam logic [2:0] JMP = 3'd3;
    localparam logic [2:0] ATC = 3'd4;
    localparam logic [2:0] UNC = 3'd0;
    localparam logic [2:0] SLT = 3'd2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b1;
    logic [7:0]  instr_address;
    logic [31:0] instruction;
    logic [7:0]  flags = 8'd0;
    logic        cond_true = 1'b0;
    logic        dec_valid;
    logic        exec_ready = 1'b1;
    logic [2:0]  dec_cmd, dec_op, flag_ack_bit;
    logic        arg1_type, arg2_type, flag_ack;
    logic [7:0]  arg1, arg2, dec_addr;

    logic [31:0] mem [0:255];
    int vectors = 0;
    int miscompares = 0;

    assign instruction = mem[instr_address];

    always #5 clock = ~clock;

    instruction_sequencer #(.RESET_ADDR(8'd0)) dut (
        .clock_i        (clock),
        .reset_i        (reset),
        .run_i          (run),
        .instr_address_o(instr_address),
        .instruction_i  (instruction),
        .flags_i        (flags),
        .cond_true_i    (cond_true),
        .dec_valid_o    (dec_valid),
        .exec_ready_i   (exec_ready),
        .dec_cmd_o      (dec_cmd),
        .dec_op_o       (dec_op),
        .arg1_type_o    (arg1_type),
        .arg1_o         (arg1),
        .arg2_type_o    (arg2_type),
        .arg2_o         (arg2),
        .dec_addr_o     (dec_addr),
        .flag_ack_o     (flag_ack),
        .flag_ack_bit_o (flag_ack_bit)
    );

    function automatic logic [31:0] enc(input logic [2:0] cmd, input logic [2:0] op,
                                        input logic t1, input logic [7:0] a1,
                                        input logic t2, input logic [7:0] a2,
                                        input logic [7:0] addr);
        return {cmd, op, t1, a1, t2, a2, addr};
    endfunction

    task automatic step();
        @(negedge clock);
    endtask

    // Reset, then let mem[0] (an unconditional jump) bring the PC to target; ends in FETCH at target.
    task automatic goto_addr(input logic [7:0] target);
        mem[0] = enc(JMP, UNC, 1'b0, 8'd0, 1'b0, 8'd0, target);
        run = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        logic [7:0] exp_addr [6];
        logic       exp_valid [6];
        exp_addr  = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1};
        exp_valid = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        mem[0] = enc(MOV, 3'd0, 1'b1, 8'h11, 1'b0, 8'h22, 8'h00);
        mem[1] = enc(JMP, UNC, 1'b0, 8'd0, 1'b0, 8'd0, 8'd1);
        run = 1'b1;
        exec_ready = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        vectors++;
        if ({dec_valid, flag_ack, dec_cmd, dec_op, arg1_type, arg1, arg2_type, arg2, dec_addr} !== 33'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: valid=%0b ack=%0b cmd=%0d arg1=%0h addr=%0h, required all zero",
                     dec_valid, flag_ack, dec_cmd, arg1, dec_addr);
        end
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (instr_address !== exp_addr[i] || dec_valid !== exp_valid[i]) begin
                miscompares++;
                $display("FAIL reset_seq[%0d]: addr=%0d valid=%0b, required addr=%0d valid=%0b",
                         i, instr_address, dec_valid, exp_addr[i], exp_valid[i]);
            end
            if (i == 1) begin
                vectors++;
                if (dec_cmd !== MOV || arg1 !== 8'h11 || arg1_type !== 1'b1 || arg2 !== 8'h22) begin
                    miscompares++;
                    $display("FAIL reset_mov_fields: cmd=%0d t1=%0b a1=%0h a2=%0h, required cmd=1 t1=1 a1=11 a2=22",
                             dec_cmd, arg1_type, arg1, arg2);
                end
            end
            step();
        end
    endtask

    task automatic test_mov_stall();
        mem[5] = enc(MOV, 3'd5, 1'b0, 8'hA5, 1'b1, 8'h3C, 8'h99);
        mem[6] = enc(JMP, UNC, 1'b0, 8'd0, 1'b0, 8'd0, 8'd6);
        goto_addr(8'd5);
        vectors++;
        if (instr_address !== 8'd5) begin
            miscompares++;
            $display("FAIL stall_fetch_addr: addr=%0d, required 5", instr_address);
        end
        exec_ready = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) exec_ready = 1'b1;
            vectors++;
            if (dec_valid !== 1'b1 || dec_cmd !== MOV || dec_op !== 3'd5 || arg1 !== 8'hA5 ||
                arg2_type !== 1'b1 || arg2 !== 8'h3C || dec_addr !== 8'h99 || instr_address !== 8'd5) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: valid=%0b cmd=%0d op=%0d a1=%0h a2=%0h addr=%0d, required valid=1 cmd=1 op=5 a1=a5 a2=3c addr=5",
                         i, dec_valid, dec_cmd, dec_op, arg1, arg2, instr_address);
            end
            step();
        end
        vectors++;
        if (instr_address !== 8'd6 || dec_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_after: addr=%0d valid=%0b, required addr=6 valid=0", instr_address, dec_valid);
        end
    endtask

    task automatic test_cond_jmp();
        mem[7] = enc(JMP, SLT, 1'b0, 8'd1, 1'b1, 8'd2, 8'd64);
        for (int c = 1; c >= 0; c--) begin
            goto_addr(8'd7);
            step();
            // opposite cond_true while stalled must be ignored
            exec_ready = 1'b0;
            cond_true = (c == 0);
            vectors++;
            if (dec_valid !== 1'b1 || dec_op !== SLT || dec_addr !== 8'd64) begin
                miscompares++;
                $display("FAIL cjmp_issue[%0d]: valid=%0b op=%0d addr=%0d, required valid=1 op=2 addr=64",
                         c, dec_valid, dec_op, dec_addr);
            end
            step();
            exec_ready = 1'b1;
            cond_true = (c == 1);
            step();
            cond_true = 1'b0;
            vectors++;
            if (instr_address !== ((c == 1) ? 8'd64 : 8'd8)) begin
                miscompares++;
                $display("FAIL cjmp_target[%0d]: addr=%0d, required %0d", c, instr_address, (c == 1) ? 64 : 8);
            end
        end
    endtask

    task automatic test_atc();
        mem[9] = enc(ATC, 3'd3, 1'b0, 8'd0, 1'b0, 8'd0, 8'd16);
        goto_addr(8'd9);
        flags = 8'b0000_1000;
        step();
        vectors++;
        if (flag_ack !== 1'b1 || flag_ack_bit !== 3'd3 || dec_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL atc_taken_ack: ack=%0b bit=%0d valid=%0b, required ack=1 bit=3 valid=0",
                     flag_ack, flag_ack_bit, dec_valid);
        end
        step();
        vectors++;
        if (instr_address !== 8'd16 || flag_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL atc_taken_target: addr=%0d ack=%0b, required addr=16 ack=0", instr_address, flag_ack);
        end
        goto_addr(8'd9);
        flags = 8'b1111_0111;
        step();
        vectors++;
        if (flag_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL atc_clear_ack: ack=%0b, required 0", flag_ack);
        end
        step();
        flags = 8'd0;
        vectors++;
        if (instr_address !== 8'd10) begin
            miscompares++;
            $display("FAIL atc_clear_target: addr=%0d, required 10", instr_address);
        end
    endtask

    task automatic test_wrap();
        mem[255] = 32'd0;
        goto_addr(8'd255);
        step();
        vectors++;
        if (dec_valid !== 1'b0 || dec_cmd !== NOP) begin
            miscompares++;
            $display("FAIL wrap_nop: valid=%0b cmd=%0d, required valid=0 cmd=0", dec_valid, dec_cmd);
        end
        step();
        vectors++;
        if (instr_address !== 8'd0) begin
            miscompares++;
            $display("FAIL wrap_target: addr=%0d, required 0", instr_address);
        end
    endtask

    task automatic test_run_hold();
        mem[20] = enc(ACC, 3'd1, 1'b1, 8'd7, 1'b0, 8'd0, 8'd0);
        exec_ready = 1'b0;
        goto_addr(8'd20);
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (instr_address !== 8'd20 || dec_valid !== 1'b0 || dec_cmd !== JMP || dec_addr !== 8'd20) begin
                miscompares++;
                $display("FAIL run_hold[%0d]: addr=%0d valid=%0b cmd=%0d ir_addr=%0d, required addr=20 valid=0 cmd=3 ir_addr=20",
                         i, instr_address, dec_valid, dec_cmd, dec_addr);
            end
        end
        run = 1'b1;
        step();
        run = 1'b0;
        exec_ready = 1'b1;
        vectors++;
        if (dec_valid !== 1'b1 || dec_cmd !== ACC || arg1 !== 8'd7) begin
            miscompares++;
            $display("FAIL run_resume: valid=%0b cmd=%0d a1=%0d, required valid=1 cmd=2 a1=7", dec_valid, dec_cmd, arg1);
        end
        step();
        vectors++;
        if (instr_address !== 8'd21) begin
            miscompares++;
            $display("FAIL run_resume_pc: addr=%0d, required 21", instr_address);
        end
        run = 1'b1;
    endtask

    task automatic test_reset_mid();
        mem[30] = enc(MOV, 3'd0, 1'b0, 8'd1, 1'b0, 8'd2, 8'd3);
        exec_ready = 1'b0;
        goto_addr(8'd30);
        step();
        step();
        vectors++;
        if (dec_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_wait: valid=%0b, required 1", dec_valid);
        end
        reset = 1'b1;
        exec_ready = 1'b1;
        step();
        reset = 1'b0;
        exec_ready = 1'b0;
        vectors++;
        if (dec_valid !== 1'b0 || instr_address !== 8'd0 || dec_cmd !== 3'd0) begin
            miscompares++;
            $display("FAIL rstmid_after: valid=%0b addr=%0d cmd=%0d, required valid=0 addr=0 cmd=0",
                     dec_valid, instr_address, dec_cmd);
        end
        exec_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_addr [5];
        logic       exp_valid [5];
        exp_addr  = '{8'd40, 8'd40, 8'd41, 8'd41, 8'd42};
        exp_valid = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        mem[40] = enc(MOV, 3'd0, 1'b0, 8'd0, 1'b0, 8'd0, 8'd0);
        mem[41] = enc(ACC, 3'd2, 1'b0, 8'd0, 1'b0, 8'd0, 8'd0);
        mem[42] = enc(JMP, UNC, 1'b0, 8'd0, 1'b0, 8'd0, 8'd42);
        exec_ready = 1'b1;
        goto_addr(8'd40);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (instr_address !== exp_addr[i] || dec_valid !== exp_valid[i]) begin
                miscompares++;
                $display("FAIL b2b[%0d]: addr=%0d valid=%0b, required addr=%0d valid=%0b",
                         i, instr_address, dec_valid, exp_addr[i], exp_valid[i]);
            end
            step();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        step();
        test_reset();
        test_mov_stall();
        test_cond_jmp();
        test_atc();
        test_wrap();
        test_run_hold();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
